scene_compositor: RTL and testbench

Per-pixel renderer directly downstream of the game-control stage. It snapshots the game-state bus (state, character positions, HP, shield and squat flags, bullets) once per frame. For each active-video pixel coordinate from the VGA timing generator, it emits 24-bit RGB through a fixed 2-stage pipeline. Layer priority is fixed, and coordinates are signed so sprites clip at screen edges.

---
 rtl/scene_compositor.sv | 239 +++++++++++++++++++++++
 tb/tb_scene_compositor.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_compositor.sv
// ============================================================================
//  Module      : scene_compositor
//  Description : Per-pixel layered renderer with per-frame game-state snapshot
//                and a fixed two-stage colour pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scene_compositor #(
    parameter int CHAR_W   = 64,
    parameter int CHAR_H   = 96,
    parameter int SQUAT_H  = 48,
    parameter int SHIELD_M = 4,
    parameter int BUL_SZ   = 8,
    parameter int HP_SEG_W = 40,
    parameter int H_ACTIVE = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    input  logic        i_px_valid,
    input  logic [10:0] i_px_x,
    input  logic [9:0]  i_px_y,
    input  logic [1:0]  i_state,
    input  logic [10:0] i_player_x,
    input  logic [9:0]  i_player_y,
    input  logic [10:0] i_enemy_x,
    input  logic [9:0]  i_enemy_y,
    input  logic [1:0]  i_player_hp,
    input  logic [1:0]  i_enemy_hp,
    input  logic        i_player_shield,
    input  logic        i_player_squat,
    input  logic        i_enemy_shield,
    input  logic        i_enemy_squat,
    input  logic [10:0] i_goodbullet_x,
    input  logic [9:0]  i_goodbullet_y,
    input  logic        i_goodbullet_isE,
    input  logic [10:0] i_badbullet_x,
    input  logic [9:0]  i_badbullet_y,
    input  logic        i_badbullet_isE,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_valid,
    output logic [5:0]  o_frame_cnt
);

    localparam logic signed [11:0] c_char_w   = 12'(CHAR_W);
    localparam logic signed [11:0] c_char_h   = 12'(CHAR_H);
    localparam logic signed [11:0] c_squat_h  = 12'(SQUAT_H);
    localparam logic signed [11:0] c_shield_m = 12'(SHIELD_M);
    localparam logic signed [11:0] c_bul_sz   = 12'(BUL_SZ);
    localparam logic signed [11:0] c_seg_w    = 12'(HP_SEG_W);
    localparam logic signed [11:0] c_h_active = 12'(H_ACTIVE);
    localparam logic signed [11:0] c_bar_y    = 12'sd8;
    localparam logic signed [11:0] c_bar_h    = 12'sd16;
    localparam logic signed [11:0] c_bar_mgn  = 12'sd8;
    localparam logic signed [11:0] c_ban_x    = 12'sd320;
    localparam logic signed [11:0] c_ban_w    = 12'sd160;
    localparam logic signed [11:0] c_ban_y    = 12'sd280;
    localparam logic signed [11:0] c_ban_h    = 12'sd40;

    localparam logic [1:0] c_st_start = 2'd0;
    localparam logic [1:0] c_st_play  = 2'd1;
    localparam logic [1:0] c_st_win   = 2'd2;
    localparam logic [1:0] c_st_lose  = 2'd3;

    // Snapshot registers
    logic [1:0]  r_state;
    logic [10:0] r_player_x, r_enemy_x, r_gb_x, r_bb_x;
    logic [9:0]  r_player_y, r_enemy_y, r_gb_y, r_bb_y;
    logic [1:0]  r_player_hp, r_enemy_hp;
    logic        r_player_shield, r_player_squat, r_enemy_shield, r_enemy_squat;
    logic        r_gb_ise, r_bb_ise;
    logic [5:0]  r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_st_start;
            r_player_x      <= '0;
            r_player_y      <= '0;
            r_enemy_x       <= '0;
            r_enemy_y       <= '0;
            r_player_hp     <= 2'd3;
            r_enemy_hp      <= 2'd3;
            r_player_shield <= 1'b0;
            r_player_squat  <= 1'b0;
            r_enemy_shield  <= 1'b0;
            r_enemy_squat   <= 1'b0;
            r_gb_x          <= '0;
            r_gb_y          <= '0;
            r_gb_ise        <= 1'b0;
            r_bb_x          <= '0;
            r_bb_y          <= '0;
            r_bb_ise        <= 1'b0;
            r_frame_cnt     <= '0;
        end else if (i_frame_start) begin
            r_state         <= i_state;
            r_player_x      <= i_player_x;
            r_player_y      <= i_player_y;
            r_enemy_x       <= i_enemy_x;
            r_enemy_y       <= i_enemy_y;
            r_player_hp     <= i_player_hp;
            r_enemy_hp      <= i_enemy_hp;
            r_player_shield <= i_player_shield;
            r_player_squat  <= i_player_squat;
            r_enemy_shield  <= i_enemy_shield;
            r_enemy_squat   <= i_enemy_squat;
            r_gb_x          <= i_goodbullet_x;
            r_gb_y          <= i_goodbullet_y;
            r_gb_ise        <= i_goodbullet_isE;
            r_bb_x          <= i_badbullet_x;
            r_bb_y          <= i_badbullet_y;
            r_bb_ise        <= i_badbullet_isE;
            r_frame_cnt     <= r_frame_cnt + 6'd1;
        end
    end

    function automatic logic in_span(input logic signed [11:0] p,
                                     input logic signed [11:0] a,
                                     input logic signed [11:0] l);
        return (p >= a) && (p < (a + l));
    endfunction

    // Returns {body, shield ring} for one character
    function automatic logic [1:0] char_hit(input logic signed [11:0] px,
                                            input logic signed [11:0] py,
                                            input logic signed [11:0] x,
                                            input logic signed [11:0] y,
                                            input logic squat,
                                            input logic shield);
        logic signed [11:0] top;
        logic signed [11:0] h;
        logic               body;
        logic               grown;
        top   = squat ? (y + c_char_h - c_squat_h) : y;
        h     = squat ? c_squat_h : c_char_h;
        body  = in_span(px, x, c_char_w) && in_span(py, top, h);
        grown = in_span(px, x - c_shield_m, c_char_w + c_shield_m + c_shield_m) &&
                in_span(py, top - c_shield_m, h + c_shield_m + c_shield_m);
        return {body, grown && !body && shield};
    endfunction

    logic signed [11:0] w_px, w_py;
    logic signed [11:0] w_php_len, w_ehp_len;
    logic [1:0]         w_p_hit, w_e_hit;
    logic               w_gb_hit, w_bb_hit, w_hp_hit, w_banner_hit;

    assign w_px      = $signed({1'b0, i_px_x});
    assign w_py      = $signed({2'b00, i_px_y});
    assign w_php_len = $signed({10'd0, r_player_hp}) * c_seg_w;
    assign w_ehp_len = $signed({10'd0, r_enemy_hp}) * c_seg_w;

    assign w_p_hit = char_hit(w_px, w_py, $signed({r_player_x[10], r_player_x}),
                              $signed({{2{r_player_y[9]}}, r_player_y}),
                              r_player_squat, r_player_shield);
    assign w_e_hit = char_hit(w_px, w_py, $signed({r_enemy_x[10], r_enemy_x}),
                              $signed({{2{r_enemy_y[9]}}, r_enemy_y}),
                              r_enemy_squat, r_enemy_shield);

    assign w_gb_hit = r_gb_ise &&
                      in_span(w_px, $signed({r_gb_x[10], r_gb_x}), c_bul_sz) &&
                      in_span(w_py, $signed({{2{r_gb_y[9]}}, r_gb_y}), c_bul_sz);
    assign w_bb_hit = r_bb_ise &&
                      in_span(w_px, $signed({r_bb_x[10], r_bb_x}), c_bul_sz) &&
                      in_span(w_py, $signed({{2{r_bb_y[9]}}, r_bb_y}), c_bul_sz);

    assign w_hp_hit = in_span(w_py, c_bar_y, c_bar_h) &&
                      (in_span(w_px, c_bar_mgn, w_php_len) ||
                       in_span(w_px, c_h_active - c_bar_mgn - w_ehp_len, w_ehp_len));

    assign w_banner_hit = !r_frame_cnt[5] &&
                          in_span(w_px, c_ban_x, c_ban_w) &&
                          in_span(w_py, c_ban_y, c_ban_h);

    // Stage 1: hit bits travel with the state they were evaluated against
    logic [6:0] r_s1_hit;
    logic [1:0] r_s1_state;
    logic       r_s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_hit   <= '0;
            r_s1_state <= c_st_start;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_hit   <= {w_bb_hit, w_gb_hit, w_p_hit[1], w_e_hit[1],
                           w_p_hit[0] | w_e_hit[0], w_hp_hit, w_banner_hit};
            r_s1_state <= r_state;
            r_s1_valid <= i_px_valid;
        end
    end

    logic [23:0] w_rgb;

    always_comb begin
        w_rgb = 24'h000000;
        if (r_s1_valid) begin
            case (r_s1_state)
                c_st_play: begin
                    if      (r_s1_hit[6]) w_rgb = 24'hFF0000;
                    else if (r_s1_hit[5]) w_rgb = 24'hFFFF00;
                    else if (r_s1_hit[4]) w_rgb = 24'h00C000;
                    else if (r_s1_hit[3]) w_rgb = 24'hC000C0;
                    else if (r_s1_hit[2]) w_rgb = 24'h00FFFF;
                    else if (r_s1_hit[1]) w_rgb = 24'hFFFFFF;
                    else                  w_rgb = 24'h000000;
                end
                c_st_start: w_rgb = r_s1_hit[0] ? 24'hFFFFFF : 24'h000040;
                c_st_win:   w_rgb = 24'h004000;
                c_st_lose:  w_rgb = 24'h400000;
                default:    w_rgb = 24'h000000;
            endcase
        end
    end

    // Stage 2
    logic [23:0] r_rgb;
    logic        r_s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb      <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_rgb      <= w_rgb;
            r_s2_valid <= r_s1_valid;
        end
    end

    assign o_r         = r_rgb[23:16];
    assign o_g         = r_rgb[15:8];
    assign o_b         = r_rgb[7:0];
    assign o_valid     = r_s2_valid;
    assign o_frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_scene_compositor.sv
// ============================================================================
//  Module      : tb_scene_compositor
//  Description : Self-checking bench for scene_compositor with a rule-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scene_compositor;

    typedef struct packed {
        logic [1:0]  state;
        logic [10:0] px;
        logic [9:0]  py;
        logic [1:0]  php;
        logic        psh;
        logic        psq;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic [1:0]  ehp;
        logic        esh;
        logic        esq;
        logic [10:0] gx;
        logic [9:0]  gy;
        logic        ge;
        logic [10:0] bx;
        logic [9:0]  by;
        logic        be;
    } game_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_frame_start;
    logic        i_px_valid;
    logic [10:0] i_px_x;
    logic [9:0]  i_px_y;
    game_t       cur;
    game_t       snap;
    int          m_cnt;
    int          total = 0;
    int          bad   = 0;

    wire [7:0] o_r, o_g, o_b;
    wire       o_valid;
    wire [5:0] o_frame_cnt;

    always #5 clk = ~clk;

    scene_compositor dut (
        .clk              (clk),
        .rst              (rst),
        .i_frame_start    (i_frame_start),
        .i_px_valid       (i_px_valid),
        .i_px_x           (i_px_x),
        .i_px_y           (i_px_y),
        .i_state          (cur.state),
        .i_player_x       (cur.px),
        .i_player_y       (cur.py),
        .i_enemy_x        (cur.ex),
        .i_enemy_y        (cur.ey),
        .i_player_hp      (cur.php),
        .i_enemy_hp       (cur.ehp),
        .i_player_shield  (cur.psh),
        .i_player_squat   (cur.psq),
        .i_enemy_shield   (cur.esh),
        .i_enemy_squat    (cur.esq),
        .i_goodbullet_x   (cur.gx),
        .i_goodbullet_y   (cur.gy),
        .i_goodbullet_isE (cur.ge),
        .i_badbullet_x    (cur.bx),
        .i_badbullet_y    (cur.by),
        .i_badbullet_isE  (cur.be),
        .o_r              (o_r),
        .o_g              (o_g),
        .o_b              (o_b),
        .o_valid          (o_valid),
        .o_frame_cnt      (o_frame_cnt)
    );

    // ---------------- reference model ----------------
    function automatic bit in_rect(int x, int y, int ax, int ay, int w, int h);
        return (x >= ax) && (x < ax + w) && (y >= ay) && (y < ay + h);
    endfunction

    function automatic bit body_at(int x, int y, int cx, int cy, bit sq);
        int top = sq ? cy + 48 : cy;
        int h   = sq ? 48 : 96;
        return in_rect(x, y, cx, top, 64, h);
    endfunction

    function automatic bit shield_at(int x, int y, int cx, int cy, bit sq, bit sh);
        int top = sq ? cy + 48 : cy;
        int h   = sq ? 48 : 96;
        return sh && in_rect(x, y, cx - 4, top - 4, 72, h + 8) && !body_at(x, y, cx, cy, sq);
    endfunction

    function automatic logic [24:0] model(game_t g, int x, int y, int fc, bit v);
        int pxx = int'($signed(g.px));
        int pyy = int'($signed(g.py));
        int exx = int'($signed(g.ex));
        int eyy = int'($signed(g.ey));
        int gxx = int'($signed(g.gx));
        int gyy = int'($signed(g.gy));
        int bxx = int'($signed(g.bx));
        int byy = int'($signed(g.by));
        int pl  = int'(g.php) * 40;
        int el  = int'(g.ehp) * 40;
        if (!v) return 25'd0;
        case (g.state)
            2'd3: return {1'b1, 24'h400000};
            2'd2: return {1'b1, 24'h004000};
            2'd0: begin
                if ((fc % 64) < 32 && in_rect(x, y, 320, 280, 160, 40))
                    return {1'b1, 24'hFFFFFF};
                return {1'b1, 24'h000040};
            end
            default: begin
                if (g.be && in_rect(x, y, bxx, byy, 8, 8)) return {1'b1, 24'hFF0000};
                if (g.ge && in_rect(x, y, gxx, gyy, 8, 8)) return {1'b1, 24'hFFFF00};
                if (body_at(x, y, pxx, pyy, g.psq)) return {1'b1, 24'h00C000};
                if (body_at(x, y, exx, eyy, g.esq)) return {1'b1, 24'hC000C0};
                if (shield_at(x, y, pxx, pyy, g.psq, g.psh) ||
                    shield_at(x, y, exx, eyy, g.esq, g.esh)) return {1'b1, 24'h00FFFF};
                if (in_rect(x, y, 8, 8, pl, 16) || in_rect(x, y, 792 - el, 8, el, 16))
                    return {1'b1, 24'hFFFFFF};
                return {1'b1, 24'h000000};
            end
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        i_frame_start = 1'b1;
        snap  = cur;
        m_cnt = (m_cnt + 1) % 64;
        step();
        i_frame_start = 1'b0;
    endtask

    task automatic pix(input int x, input int y, output logic [23:0] rgb, output logic v);
        i_px_valid = 1'b1;
        i_px_x     = 11'(x);
        i_px_y     = 10'(y);
        step();
        i_px_valid = 1'b0;
        step();
        rgb = {o_r, o_g, o_b};
        v   = o_valid;
    endtask

    task automatic default_game();
        cur     = '0;
        cur.state = 2'd1;
        cur.php = 2'd3;
        cur.ehp = 2'd3;
        cur.px  = 11'd400;
        cur.py  = 10'd400;
        cur.ex  = 11'd600;
        cur.ey  = 10'd400;
    endtask

    task automatic rand_game();
        int v;
        cur.state = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
        v = int'($urandom_range(0, 1000)) - 100; cur.px = v[10:0];
        v = int'($urandom_range(0, 700)) - 100;  cur.py = v[9:0];
        v = int'($urandom_range(0, 1000)) - 100; cur.ex = v[10:0];
        v = int'($urandom_range(0, 700)) - 100;  cur.ey = v[9:0];
        v = int'($urandom_range(0, 900)) - 50;   cur.gx = v[10:0];
        v = int'($urandom_range(0, 650)) - 50;   cur.gy = v[9:0];
        v = int'($urandom_range(0, 900)) - 50;   cur.bx = v[10:0];
        v = int'($urandom_range(0, 650)) - 50;   cur.by = v[9:0];
        cur.php = 2'($urandom_range(0, 3));
        cur.ehp = 2'($urandom_range(0, 3));
        cur.psh = 1'($urandom_range(0, 1));
        cur.psq = 1'($urandom_range(0, 1));
        cur.esh = 1'($urandom_range(0, 1));
        cur.esq = 1'($urandom_range(0, 1));
        cur.ge  = 1'($urandom_range(0, 1));
        cur.be  = 1'($urandom_range(0, 1));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [23:0] rgb;
        logic        v;
        total++; if ({o_r, o_g, o_b} !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=000000", {o_r, o_g, o_b}); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        total++; if (o_frame_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_frame_cnt); end
        pix(0, 0, rgb, v);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL reset_px_valid got=%b exp=1", v); end
        total++; if (rgb !== 24'h000040) begin bad++; $display("FAIL reset_px_rgb got=%h exp=000040", rgb); end
    endtask

    task automatic test_body();
        logic [23:0] rgb;
        logic        v;
        default_game();
        cur.px = 11'd100; cur.py = 10'd200;
        pulse();
        pix(100, 200, rgb, v);
        total++; if (rgb !== 24'h00C000) begin bad++; $display("FAIL body_in got=%h exp=00C000", rgb); end
        pix(164, 200, rgb, v);
        total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL body_right got=%h exp=000000", rgb); end
        pix(99, 200, rgb, v);
        total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL body_left got=%h exp=000000", rgb); end
        cur.psq = 1'b1;
        pulse();
        pix(100, 247, rgb, v);
        total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL squat_above got=%h exp=000000", rgb); end
        pix(100, 248, rgb, v);
        total++; if (rgb !== 24'h00C000) begin bad++; $display("FAIL squat_top got=%h exp=00C000", rgb); end
    endtask

    task automatic test_bullet();
        logic [23:0] rgb;
        logic        v;
        default_game();
        cur.px = 11'd100; cur.py = 10'd200;
        cur.gx = 11'd130; cur.gy = 10'd220; cur.ge = 1'b1;
        pulse();
        pix(130, 220, rgb, v);
        total++; if (rgb !== 24'hFFFF00) begin bad++; $display("FAIL goodbullet got=%h exp=FFFF00", rgb); end
        cur.bx = 11'd132; cur.by = 10'd222; cur.be = 1'b1;
        pulse();
        pix(133, 223, rgb, v);
        total++; if (rgb !== 24'hFF0000) begin bad++; $display("FAIL badbullet_prio got=%h exp=FF0000", rgb); end
        cur.ge = 1'b0; cur.be = 1'b0;
        pulse();
        pix(130, 220, rgb, v);
        total++; if (rgb !== 24'h00C000) begin bad++; $display("FAIL bullet_absent got=%h exp=00C000", rgb); end
    endtask

    task automatic test_shield();
        logic [23:0] rgb;
        logic        v;
        int          n;
        default_game();
        n = -20;
        cur.ex = n[10:0]; cur.ey = 10'd100; cur.esh = 1'b1;
        pulse();
        pix(0, 100, rgb, v);
        total++; if (rgb !== 24'hC000C0) begin bad++; $display("FAIL enemy_clip got=%h exp=C000C0", rgb); end
        pix(44, 100, rgb, v);
        total++; if (rgb !== 24'h00FFFF) begin bad++; $display("FAIL shield_ring got=%h exp=00FFFF", rgb); end
        pix(48, 100, rgb, v);
        total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL shield_out got=%h exp=000000", rgb); end
    endtask

    task automatic test_hp();
        logic [23:0] rgb;
        logic        v;
        default_game();
        cur.php = 2'd2; cur.ehp = 2'd1;
        pulse();
        pix(87, 10, rgb, v);
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL php_last got=%h exp=FFFFFF", rgb); end
        pix(88, 10, rgb, v);
        total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL php_end got=%h exp=000000", rgb); end
        pix(751, 10, rgb, v);
        total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL ehp_before got=%h exp=000000", rgb); end
        pix(752, 10, rgb, v);
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL ehp_first got=%h exp=FFFFFF", rgb); end
    endtask

    task automatic test_snapshot();
        logic [23:0] rgb;
        logic        v;
        default_game();
        cur.px = 11'd100; cur.py = 10'd200;
        pulse();
        cur.px = 11'd300;
        pix(100, 200, rgb, v);
        total++; if (rgb !== 24'h00C000) begin bad++; $display("FAIL no_pulse_change got=%h exp=00C000", rgb); end
        i_px_valid    = 1'b1;
        i_px_x        = 11'd100;
        i_px_y        = 10'd200;
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        snap  = cur;
        m_cnt = (m_cnt + 1) % 64;
        step();
        i_px_valid = 1'b0;
        total++; if ({o_r, o_g, o_b} !== 24'h00C000) begin bad++; $display("FAIL coincident_old got=%h exp=00C000", {o_r, o_g, o_b}); end
        step();
        total++; if ({o_r, o_g, o_b} !== 24'h000000) begin bad++; $display("FAIL coincident_new got=%h exp=000000", {o_r, o_g, o_b}); end
    endtask

    task automatic test_frame_cnt();
        for (int i = 0; i < 66; i++) begin
            pulse();
            total++;
            if (int'(o_frame_cnt) !== m_cnt) begin
                bad++; $display("FAIL frame_cnt got=%0d exp=%0d", o_frame_cnt, m_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] rgb;
        logic        v;
        default_game();
        cur.px = 11'd100;
        i_frame_start = 1'b1;
        step();
        cur.px = 11'd500;
        step();
        i_frame_start = 1'b0;
        snap  = cur;
        m_cnt = (m_cnt + 2) % 64;
        total++; if (int'(o_frame_cnt) !== m_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", o_frame_cnt, m_cnt); end
        pix(500, 400, rgb, v);
        total++; if (rgb !== 24'h00C000) begin bad++; $display("FAIL b2b_last_wins got=%h exp=00C000", rgb); end
        pix(100, 400, rgb, v);
        total++; if (rgb !== 24'h000000) begin bad++; $display("FAIL b2b_first_gone got=%h exp=000000", rgb); end
    endtask

    task automatic test_random();
        logic [24:0] q[$];
        logic [24:0] e;
        int          x, y, sel;
        bit          v, p;
        i_px_valid = 1'b0;
        step();
        step();
        q.push_back(25'd0);
        q.push_back(25'd0);
        for (int n = 0; n < 1500; n++) begin
            e = q.pop_front();
            total++;
            if ({o_valid, o_r, o_g, o_b} !== e) begin
                bad++; $display("FAIL random_px n=%0d got=%h exp=%h", n, {o_valid, o_r, o_g, o_b}, e);
            end
            rand_game();
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: begin x = int'($signed(snap.px)); y = int'($signed(snap.py)); end
                1: begin x = int'($signed(snap.ex)); y = int'($signed(snap.ey)); end
                2: begin x = int'($signed(snap.gx)); y = int'($signed(snap.gy)); end
                3: begin x = int'($signed(snap.bx)); y = int'($signed(snap.by)); end
                4: begin x = 300; y = 270; end
                default: begin x = 0; y = 0; end
            endcase
            x = x + int'($urandom_range(0, 90)) - 10;
            y = y + int'($urandom_range(0, 120)) - 10;
            if (sel == 5) begin x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 30)); end
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            if (x > 1023) x = 1023;
            if (y > 599) y = 599;
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 19) == 0);
            i_px_valid = v;
            i_px_x     = 11'(x);
            i_px_y     = 10'(y);
            q.push_back(model(snap, x, y, m_cnt, v));
            if (p) begin
                i_frame_start = 1'b1;
                snap  = cur;
                m_cnt = (m_cnt + 1) % 64;
            end else begin
                i_frame_start = 1'b0;
            end
            step();
        end
        i_frame_start = 1'b0;
        i_px_valid    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = q.pop_front();
            total++;
            if ({o_valid, o_r, o_g, o_b} !== e) begin
                bad++; $display("FAIL random_drain got=%h exp=%h", {o_valid, o_r, o_g, o_b}, e);
            end
            step();
        end
        total++; if (int'(o_frame_cnt) !== m_cnt) begin bad++; $display("FAIL random_cnt got=%0d exp=%0d", o_frame_cnt, m_cnt); end
    endtask

    task automatic test_reset_midline();
        logic [23:0] rgb;
        logic        v;
        default_game();
        pulse();
        i_px_valid = 1'b1;
        i_px_x     = 11'd410;
        i_px_y     = 10'd410;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
        total++; if ({o_r, o_g, o_b} !== 24'h0) begin bad++; $display("FAIL midrst_rgb got=%h exp=000000", {o_r, o_g, o_b}); end
        total++; if (o_frame_cnt !== 6'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", o_frame_cnt); end
        i_px_valid = 1'b0;
        step();
        rst   = 1'b0;
        m_cnt = 0;
        step();
        step();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL postrst_idle got=%b exp=0", o_valid); end
        pix(400, 300, rgb, v);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL postrst_valid got=%b exp=1", v); end
        total++; if (rgb !== 24'hFFFFFF) begin bad++; $display("FAIL postrst_banner got=%h exp=FFFFFF", rgb); end
    endtask

    initial begin
        rst           = 1'b1;
        i_frame_start = 1'b0;
        i_px_valid    = 1'b0;
        i_px_x        = '0;
        i_px_y        = '0;
        cur           = '0;
        m_cnt         = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_body();
        test_bullet();
        test_shield();
        test_hp();
        test_snapshot();
        test_frame_cnt();
        test_back_to_back();
        test_random();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
